// File: rtl/comb_sweep_pkg.sv
// Shared types and sizing for the combinational-block sweep controller.
// One vector per input combination of a 4-input function block.
package comb_sweep_pkg;

  localparam int unsigned NUM_VEC  = 16;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned SETTLE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

endpackage

// File: rtl/comb_sweep_ctrl.sv
// Sweeps a 4-input combinational block through all 16 vectors, captures its truth table
// and scores it against an expected table latched at start.
module comb_sweep_ctrl
  import comb_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [NUM_VEC-1:0] expected_i,
  input  logic               y_i,
  output logic               a_o,
  output logic               b_o,
  output logic               c_o,
  output logic               d_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [NUM_VEC-1:0] truth_table_o,
  output logic [CNT_W-1:0]   mismatch_cnt_o,
  output logic [IDX_W-1:0]   first_fail_o,
  output logic               pass_o
);

  localparam logic [SETTLE_W-1:0] SettleInit = SETTLE_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0]    LastIdx    = IDX_W'(NUM_VEC - 1);

  state_e               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [SETTLE_W-1:0]  settle_q;
  logic [NUM_VEC-1:0]   exp_q;
  logic [NUM_VEC-1:0]   tt_q;
  logic [CNT_W-1:0]     mm_q;
  logic [CNT_W-1:0]     mm_d;
  logic [IDX_W-1:0]     ff_q;
  logic                 pass_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 miss;

  // y is the only unregistered input; it feeds the capture and scoring logic directly.
  always_comb begin
    miss = y_i ^ exp_q[idx_q];
    mm_d = mm_q + CNT_W'(miss);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      settle_q <= '0;
      exp_q    <= '0;
      tt_q     <= '0;
      mm_q     <= '0;
      ff_q     <= '0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            exp_q    <= expected_i;
            idx_q    <= '0;
            settle_q <= SettleInit;
            tt_q     <= '0;
            mm_q     <= '0;
            ff_q     <= '0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= StSettle;
          end
        end
        StSettle: begin
          if (settle_q == '0) begin
            state_q <= StSample;
          end else begin
            settle_q <= settle_q - SETTLE_W'(1);
          end
        end
        StSample: begin
          tt_q[idx_q] <= y_i;
          mm_q        <= mm_d;
          if (miss && (mm_q == '0)) begin
            ff_q <= idx_q;
          end
          if (idx_q == LastIdx) begin
            // pass and done are registered together so pass is valid alongside done.
            done_q  <= 1'b1;
            pass_q  <= (mm_d == '0);
            state_q <= StDone;
          end else begin
            idx_q    <= idx_q + IDX_W'(1);
            settle_q <= SettleInit;
            state_q  <= StSettle;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign {a_o, b_o, c_o, d_o} = idx_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign truth_table_o  = tt_q;
  assign mismatch_cnt_o = mm_q;
  assign first_fail_o   = ff_q;
  assign pass_o         = pass_q;

  done_implies_busy: assert property (@(posedge clk) disable iff (!rst_n) done_o |-> busy_o);
  mm_in_range: assert property (@(posedge clk) disable iff (!rst_n) mismatch_cnt_o <= CNT_W'(16));

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Scoreboard bench for comb_sweep_ctrl: stimulus pushes expected sweep results, a monitor
// pops and compares them on every done pulse.
module tb_comb_sweep_ctrl;
  import comb_sweep_pkg::*;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  mm;
    logic [3:0]  ff;
    logic        pass;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] expected;
  int          sel;
  int          model;

  logic        a1, b1, c1, d1, y1, busy1, done1, pass1;
  logic [15:0] tt1;
  logic [4:0]  mm1;
  logic [3:0]  ff1;
  logic        a3, b3, c3, d3, y3, busy3, done3, pass3;
  logic [15:0] tt3;
  logic [4:0]  mm3;
  logic [3:0]  ff3;

  logic        start1, start3;
  logic [3:0]  abcd_s;
  logic        busy_s, done_s, pass_s;
  logic [15:0] tt_s;
  logic [4:0]  mm_s;
  logic [3:0]  ff_s;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic fblk(input logic [3:0] v);
    case (model)
      0:       return ^v;
      1:       return &v;
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    y1     = fblk({a1, b1, c1, d1});
    y3     = fblk({a3, b3, c3, d3});
    start1 = start && (sel == 1);
    start3 = start && (sel == 3);
    abcd_s = (sel == 3) ? {a3, b3, c3, d3} : {a1, b1, c1, d1};
    busy_s = (sel == 3) ? busy3 : busy1;
    done_s = (sel == 3) ? done3 : done1;
    pass_s = (sel == 3) ? pass3 : pass1;
    tt_s   = (sel == 3) ? tt3 : tt1;
    mm_s   = (sel == 3) ? mm3 : mm1;
    ff_s   = (sel == 3) ? ff3 : ff1;
  end

  comb_sweep_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .expected_i(expected), .y_i(y1),
    .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1), .busy_o(busy1), .done_o(done1),
    .truth_table_o(tt1), .mismatch_cnt_o(mm1), .first_fail_o(ff1), .pass_o(pass1)
  );

  comb_sweep_ctrl #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_i(start3), .expected_i(expected), .y_i(y3),
    .a_o(a3), .b_o(b3), .c_o(c3), .d_o(d3), .busy_o(busy3), .done_o(done3),
    .truth_table_o(tt3), .mismatch_cnt_o(mm3), .first_fail_o(ff3), .pass_o(pass3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency is measured from the busy rise (the accepted start edge).
  initial begin
    int   t0;
    logic busy_prev;
    exp_t e;
    t0 = 0;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_prev = 1'b0;
      end else begin
        if (busy_s && !busy_prev) t0 = cyc;
        if (done_s) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("truth_table", 32'(tt_s), 32'(e.tt));
            chk("mismatch_cnt", 32'(mm_s), 32'(e.mm));
            chk("first_fail", 32'(ff_s), 32'(e.ff));
            chk("pass", 32'(pass_s), 32'(e.pass));
            chk("done_latency", 32'(cyc - t0), 32'(e.lat));
          end
        end
        busy_prev = busy_s;
      end
    end
  end

  task automatic push(input logic [15:0] tt, input logic [4:0] mm, input logic [3:0] ff,
                      input logic pass, input int lat);
    exp_t e;
    e.tt = tt; e.mm = mm; e.ff = ff; e.pass = pass; e.lat = lat;
    sb_q.push_back(e);
  endtask

  // Leaves the bench at the negedge just after the accepting edge.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_s !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done_s), 32'd1);
  endtask

  task automatic wait_vec(input logic [3:0] v, input int budget);
    int n = 0;
    while (abcd_s !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vector", 32'(abcd_s), 32'(v));
  endtask

  task automatic wait_busy_rise(input int budget);
    int   n = 0;
    logic prev;
    prev = busy_s;
    forever begin
      @(negedge clk);
      n++;
      if ((busy_s && !prev) || n >= budget) break;
      prev = busy_s;
    end
    chk("busy_rise", 32'(busy_s), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy_s), 32'd0);
    chk({tag, "_done"}, 32'(done_s), 32'd0);
    chk({tag, "_pass"}, 32'(pass_s), 32'd0);
    chk({tag, "_tt"}, 32'(tt_s), 32'h0);
    chk({tag, "_mm"}, 32'(mm_s), 32'd0);
    chk({tag, "_ff"}, 32'(ff_s), 32'd0);
    chk({tag, "_abcd"}, 32'(abcd_s), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; expected = 16'h0; sel = 1; model = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Parity block, matching table.
    expected = 16'h6996;
    push(16'h6996, 5'd0, 4'd0, 1'b1, 32);
    do_start();
    chk("busy_after_start", 32'(busy_s), 32'd1);
    chk("vec0_driven", 32'(abcd_s), 32'd0);
    wait_done(200);
    repeat (2) @(negedge clk);
    chk("pass_held", 32'(pass_s), 32'd1);
    chk("busy_fell", 32'(busy_s), 32'd0);
    chk("tt_held", 32'(tt_s), 32'h6996);

    // One mismatch at vector 0; results from the previous sweep must be cleared.
    expected = 16'h6997;
    push(16'h6996, 5'd1, 4'd0, 1'b0, 32);
    do_start();
    chk("pass_cleared", 32'(pass_s), 32'd0);
    chk("tt_cleared", 32'(tt_s), 32'h0);
    wait_done(200);

    // AND block: only vector 15 mismatches.
    model = 1; expected = 16'h0000;
    push(16'h8000, 5'd1, 4'd15, 1'b0, 32);
    do_start();
    wait_done(200);

    // Constant-1 block on the SETTLE=3 instance: every vector fails, each held 4 cycles.
    sel = 3; model = 2; expected = 16'h0000;
    push(16'hFFFF, 5'd16, 4'd0, 1'b0, 64);
    do_start();
    for (int v = 0; v < 16; v++) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("vec_hold_%0d_%0d", v, k), 32'(abcd_s), 32'(v));
        @(negedge clk);
      end
    end
    wait_done(10);
    sel = 1;

    // A second start mid-sweep is ignored.
    model = 0; expected = 16'h6996;
    push(16'h6996, 5'd0, 4'd0, 1'b1, 32);
    do_start();
    wait_vec(4'd5, 100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_during_ignored", 32'(busy_s), 32'd1);
    wait_done(200);

    // Reset at vector 9 discards partial results immediately.
    expected = 16'h0000;
    do_start();
    wait_vec(4'd9, 100);
    chk("partial_mm_nonzero", 32'(mm_s != 5'd0), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    chk("midreset_state", 32'(dut1.state_q), 32'(StIdle));
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh sweep after reset.
    model = 1; expected = 16'h8000;
    push(16'h8000, 5'd0, 4'd0, 1'b1, 32);
    do_start();
    wait_done(200);

    // start held high: three back-to-back sweeps, each re-clearing its results.
    model = 0; expected = 16'h6990;
    for (int k = 0; k < 3; k++) push(16'h6996, 5'd2, 4'd1, 1'b0, 32);
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_busy_rise(50);
      chk($sformatf("b2b_tt_clear_%0d", k), 32'(tt_s), 32'h0);
      chk($sformatf("b2b_mm_clear_%0d", k), 32'(mm_s), 32'd0);
      chk($sformatf("b2b_pass_clear_%0d", k), 32'(pass_s), 32'd0);
      wait_done(200);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_after_b2b", 32'(busy_s), 32'd0);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/comb_sweep_ctrl.md
# comb_sweep_ctrl

Sequencer that exhaustively exercises a 4-input combinational function block (ports a, b, c, d -> y). On a start request it drives all 16 input combinations in ascending order, waits a programmable settle time per vector, captures y into a 16-bit truth table, and compares each captured bit against a supplied expected table. It sits beside the combinational block as its on-chip characterisation/self-test controller, replacing hand-stepped stimulus with a start/done handshake.

## Interface
- SETTLE, default 1: cycles each vector is held before y is sampled; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous assert, active-low. Deassertion is synchronised to clk externally.
- start  input  1  sweep request; sampled only in IDLE.
- expected  input  16  expected truth table; bit i is the expected y for vector i; latched on the accepted start.
- y  input  1  output of the function block under control.
- a, b, c, d  output  1 each  registered drive to the function block; {a,b,c,d} = vector index, with a as the MSB.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse when the sweep completes.
- truth_table  output  16  captured y values; bit i = vector i.
- mismatch_cnt  output  5  number of vectors where the captured y differs from expected (0..16).
- first_fail  output  4  index of the lowest mismatching vector; valid only when mismatch_cnt != 0.
- pass  output  1  high with done and held afterwards when mismatch_cnt == 0; cleared on the next accepted start.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1:
  - latch expected.
  - idx <- 0, settle_cnt <- SETTLE-1.
  - clear truth_table, mismatch_cnt, first_fail and pass.
  - go to SETTLE.
- SETTLE: {a,b,c,d} = idx. When settle_cnt == 0, go to SAMPLE; otherwise decrement settle_cnt.
- SAMPLE:
  - truth_table[idx] <- y.
  - If y != exp[idx]: mismatch_cnt++. If this is the first mismatch, first_fail <- idx.
  - If idx == 15, go to DONE. Otherwise idx++, settle_cnt <- SETTLE-1, and go to SETTLE.
- DONE: done=1 for one cycle. pass <- (mismatch_cnt == 0), using the value after the final SAMPLE update. Go to IDLE.
- start while busy is ignored; no queueing.
- start held high in IDLE after DONE starts a new sweep; back-to-back sweeps are legal.
- idx is 4 bits and never wraps inside a sweep; the terminal test is idx == 15.
- mismatch_cnt is 5 bits so that 16 mismatches does not overflow.
- truth_table, mismatch_cnt, first_fail and pass hold their values in IDLE until the next accepted start.

## Timing
- Reset values:
  - state = IDLE.
  - a = b = c = d = 0.
  - busy = 0, done = 0, pass = 0.
  - truth_table = 16'h0000.
  - mismatch_cnt = 0, first_fail = 0.
- Reset asserted mid-sweep: all of the above take effect immediately (asynchronously). The partial results are discarded.
- The start edge is T0. busy rises at T0. Vector 0 is driven from T0.
- Each vector is held for SETTLE+1 cycles: SETTLE cycles in SETTLE, then 1 cycle in SAMPLE. y is captured at the closing edge of SAMPLE.
- done is high in the cycle following edge T0 + 16*(SETTLE+1). busy falls at the same edge done falls.
  - SETTLE=1: done in cycle 32 after start.
  - SETTLE=3: done in cycle 64 after start.
- y must be stable for at least SETTLE cycles after {a,b,c,d} changes. The combinational path from y to the capture register is the only unregistered input path.

## Structure
- Package comb_sweep_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE).
  - NUM_VEC = 16.
  - IDX_W = 4.
  - CNT_W = 5.
- Single module, with no sub-module required. The settle down-counter is inline; it is too small to justify a separate counter module.
- The function block is instantiated by the enclosing top or bench, not inside this controller.

## Test plan
- Function model y = a^b^c^d, expected = 16'h6996, SETTLE=1, pulse start -> done in cycle 32, truth_table = 16'h6996, mismatch_cnt = 0, pass = 1.
- Same model, expected = 16'h6997 -> mismatch_cnt = 1, first_fail = 0, pass = 0.
- Model y = a&b&c&d, expected = 16'h0000 -> truth_table = 16'h8000, mismatch_cnt = 1, first_fail = 15.
- Model y = 1, expected = 16'h0000, SETTLE=3 -> done in cycle 64, mismatch_cnt = 16, first_fail = 0; check a..d step 0..15 with each vector held for 4 cycles.
- Pulse start again at vector 5 during a sweep -> ignored, and the sweep completes normally. Then assert rst_n=0 at vector 9 -> all outputs return to their reset values immediately and state is IDLE. A fresh start then produces a complete correct sweep.
- start held high continuously -> back-to-back sweeps. Each sweep yields one done pulse, and the results are re-cleared at each accepted start.
